pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_INDEX_BIT_WIDTH, default 4, register index width.
REQ-002 SHALL have parameter STAGES, default 2, range 1..4: in-flight stages after decode; stage 0 = EX, stage STAGES-1 = writeback.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = stall on every RAW hazard.
REQ-004 SHALL have parameter CNT_BITS, default 32, width of the performance counters.
REQ-005 SHALL have ports: clk  in  1  clock. Only one clock; all state on rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: id_valid  in  1  decode holds a real instruction.
REQ-008 SHALL have ports: id_rd_idx1, id_rd_idx2  in  REG_INDEX_BIT_WIDTH  source indices.
REQ-009 SHALL have ports: id_use1, id_use2  in  1  source actually read.
REQ-010 SHALL have ports: id_wrt_en  in  1, id_wrt_idx  in  REG_INDEX_BIT_WIDTH, id_is_load  in  1  decode destination info.
REQ-011 SHALL have ports: ex_br_taken  in  1  branch/JAL redirect resolved in stage 0.
REQ-012 SHALL have ports: stall  out  1  hold PC and decode.
REQ-013 SHALL have ports: flush  out  1  discard decode instruction.
REQ-014 SHALL have ports: fwd_sel1, fwd_sel2  out  3  0 = register file, k+1 = stage k result.
REQ-015 SHALL have ports: stage_valid  out  STAGES, stage_wrt_idx  out  STAGES*REG_INDEX_BIT_WIDTH  scoreboard view.
REQ-016 SHALL have ports: stall_cnt, flush_cnt  out  CNT_BITS  event counters.

Function
REQ-017 SHALL keep per stage a scoreboard entry {valid, wrt_en, wrt_idx, is_load}.
REQ-018 SHALL each cycle shift entry k into k+1; entry STAGES-1 retires.
REQ-019 SHALL load stage 0 with decode info when id_valid & ~stall & ~flush; otherwise stage 0 gets a bubble (valid=0).
REQ-020 SHALL match a used source against valid entries with wrt_en and equal index; the youngest (lowest k) match wins; index 0 is not special.
REQ-021 SHALL, with FWD_EN=1, assert stall when the winning match is stage 0 with is_load (load-use); otherwise drive fwd_sel = k+1.
REQ-022 SHALL, with FWD_EN=0, assert stall on any match and drive fwd_sel = 0.
REQ-023 SHALL drive fwd_sel = 0 for an unused source, no match, or id_valid=0.
REQ-024 SHALL make stall, flush and fwd_sel combinational from current inputs and scoreboard (zero-cycle latency).
REQ-025 SHALL assert flush = ex_br_taken & stage_valid[0]; ex_br_taken with stage 0 invalid is ignored.
REQ-026 SHALL give flush priority: flush forces stall=0 in the same cycle.
REQ-027 SHALL release a load-use stall after exactly one cycle (load moves to stage 1) when STAGES>=2; with FWD_EN=0 a stall lasts until the producer retires.
REQ-028 SHALL increment stall_cnt on each stall cycle and flush_cnt on each flush cycle, saturating at all-ones.

Reset
REQ-029 SHALL on reset clear all scoreboard entries to zero and both counters to 0.
REQ-030 SHALL drive stall=0, flush=0, fwd_sel=0 while reset is high, regardless of inputs.
REQ-031 SHALL discard in-flight entries when reset is asserted mid-operation; the first post-reset cycle sees an empty scoreboard.

Structure
REQ-032 SHALL place the scoreboard entry typedef, fwd_sel encoding constants and the opcode constants (OP1_LW, OP1_BCOND, OP1_JAL) in a shared pipeline package.
REQ-033 SHALL implement the per-source match/priority logic as one sub-module, hazard_match, instantiated twice.

Verification
REQ-034 SHALL cover: load r3 then add reading r3, STAGES=2, FWD_EN=1 -> stall=1 one cycle, stall_cnt=1, then fwd_sel1=2.
REQ-035 SHALL cover: add r5 then add reading r5 on both sources -> stall=0, fwd_sel1=fwd_sel2=1.
REQ-036 SHALL cover: ex_br_taken=1 with stage 0 valid while decode has load-use hazard -> flush=1, stall=0, stage 0 bubble next cycle, flush_cnt=1.
REQ-037 SHALL cover: FWD_EN=0, STAGES=3, add r2 then reader of r2 -> stall=1 for 3 cycles, then fwd_sel=0.
REQ-038 SHALL cover: reset asserted with 2 valid entries -> next cycle stage_valid=0, counters 0, no stall for prior dependents.
REQ-039 SHALL cover: CNT_BITS=4, 20 consecutive stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: scoreboard entry layout, forwarding-select
// encoding and the primary opcode constants used by the decode stage.
package pipe_hazard_ctrl_pkg;

   // Scoreboard index storage is sized for the widest register file supported;
   // narrower register indices are zero-extended on entry.
   localparam int SB_IDX_W = 16;

   typedef struct packed {
      logic                valid;
      logic                wrt_en;
      logic [SB_IDX_W-1:0] wrt_idx;
      logic                is_load;
   } sb_entry_t;

   localparam logic [2:0] FWD_RF     = 3'd0;
   localparam logic [2:0] FWD_STAGE0 = 3'd1;
   localparam logic [2:0] FWD_STAGE1 = 3'd2;
   localparam logic [2:0] FWD_STAGE2 = 3'd3;
   localparam logic [2:0] FWD_STAGE3 = 3'd4;

   localparam logic [6:0] OP1_LW    = 7'b0000011;
   localparam logic [6:0] OP1_BCOND = 7'b1100011;
   localparam logic [6:0] OP1_JAL   = 7'b1101111;

   function automatic logic [2:0] fwd_code(input logic [1:0] stage);
      return {1'b0, stage} + 3'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Per-source hazard detection: finds the youngest in-flight producer of one
// decode source and decides between forwarding from it and stalling.
module hazard_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int STAGES = 2,
   parameter bit FWD_EN = 1'b1
) (
   input  logic                i_valid,
   input  logic                i_use,
   input  logic [SB_IDX_W-1:0] i_idx,
   input  sb_entry_t           i_sb [STAGES],
   output logic                o_stall,
   output logic [2:0]          o_fwd_sel
);

   logic       w_hit;
   logic       w_hit_load;
   logic [1:0] w_hit_stage;

   // Scan oldest to youngest so the lowest matching stage is left standing.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_load  = 1'b0;
      w_hit_stage = 2'd0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (i_sb[k].valid && i_sb[k].wrt_en && (i_sb[k].wrt_idx == i_idx)) begin
            w_hit       = 1'b1;
            w_hit_load  = i_sb[k].is_load;
            w_hit_stage = 2'(k);
         end
      end
   end

   always_comb begin
      o_stall   = 1'b0;
      o_fwd_sel = FWD_RF;
      if (i_valid && i_use && w_hit) begin
         if (!FWD_EN) begin
            o_stall = 1'b1;
         end else if ((w_hit_stage == 2'd0) && w_hit_load) begin
            o_stall = 1'b1;
         end else begin
            o_fwd_sel = fwd_code(w_hit_stage);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations in a shifting
// scoreboard and produces stall, flush and operand-forwarding selects.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int STAGES              = 2,
   parameter bit FWD_EN              = 1'b1,
   parameter int CNT_BITS            = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  id_valid,
   input  logic [REG_INDEX_BIT_WIDTH-1:0]        id_rd_idx1,
   input  logic [REG_INDEX_BIT_WIDTH-1:0]        id_rd_idx2,
   input  logic                                  id_use1,
   input  logic                                  id_use2,
   input  logic                                  id_wrt_en,
   input  logic [REG_INDEX_BIT_WIDTH-1:0]        id_wrt_idx,
   input  logic                                  id_is_load,
   input  logic                                  ex_br_taken,
   output logic                                  stall,
   output logic                                  flush,
   output logic [2:0]                            fwd_sel1,
   output logic [2:0]                            fwd_sel2,
   output logic [STAGES-1:0]                     stage_valid,
   output logic [STAGES*REG_INDEX_BIT_WIDTH-1:0] stage_wrt_idx,
   output logic [CNT_BITS-1:0]                   stall_cnt,
   output logic [CNT_BITS-1:0]                   flush_cnt
);

   sb_entry_t           r_sb [STAGES];
   logic [CNT_BITS-1:0] r_stall_cnt;
   logic [CNT_BITS-1:0] r_flush_cnt;

   logic                w_stall1;
   logic                w_stall2;
   logic [2:0]          w_sel1;
   logic [2:0]          w_sel2;
   logic                w_flush;
   logic                w_stall;
   sb_entry_t           w_id_entry;

   hazard_match #(.STAGES(STAGES), .FWD_EN(FWD_EN)) u_match1 (
      .i_valid   (id_valid),
      .i_use     (id_use1),
      .i_idx     (SB_IDX_W'(id_rd_idx1)),
      .i_sb      (r_sb),
      .o_stall   (w_stall1),
      .o_fwd_sel (w_sel1)
   );

   hazard_match #(.STAGES(STAGES), .FWD_EN(FWD_EN)) u_match2 (
      .i_valid   (id_valid),
      .i_use     (id_use2),
      .i_idx     (SB_IDX_W'(id_rd_idx2)),
      .i_sb      (r_sb),
      .o_stall   (w_stall2),
      .o_fwd_sel (w_sel2)
   );

   // A taken redirect kills decode, so any hazard it has is moot.
   assign w_flush = ex_br_taken & r_sb[0].valid & ~reset;
   assign w_stall = (w_stall1 | w_stall2) & ~w_flush & ~reset;

   always_comb begin
      w_id_entry         = '0;
      w_id_entry.valid   = 1'b1;
      w_id_entry.wrt_en  = id_wrt_en;
      w_id_entry.wrt_idx = SB_IDX_W'(id_wrt_idx);
      w_id_entry.is_load = id_is_load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sb        <= '{default: '0};
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         for (int k = STAGES - 1; k >= 1; k--) begin
            r_sb[k] <= r_sb[k-1];
         end
         r_sb[0] <= (id_valid && !w_stall && !w_flush) ? w_id_entry : '0;
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
         end
         if (w_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_BITS'(1);
         end
      end
   end

   assign stall     = w_stall;
   assign flush     = w_flush;
   assign fwd_sel1  = reset ? FWD_RF : w_sel1;
   assign fwd_sel2  = reset ? FWD_RF : w_sel2;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   always_comb begin
      stage_valid   = '0;
      stage_wrt_idx = '0;
      for (int k = 0; k < STAGES; k++) begin
         stage_valid[k] = r_sb[k].valid;
         stage_wrt_idx[k*REG_INDEX_BIT_WIDTH +: REG_INDEX_BIT_WIDTH] =
            r_sb[k].wrt_idx[REG_INDEX_BIT_WIDTH-1:0];
      end
   end

endmodule
